// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD add/sub unit.
// master drives the request side; slave is the arithmetic unit.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  carry_out;
    logic                  neg;
    logic                  err;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, neg, err
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, neg, err
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD8421 adder/subtractor, one tetrad per clock, LSD first, sign-magnitude result.
// Latency start->done: DIGITS+1 (add / non-negative sub), 2*DIGITS+1 (negative sub), 1 (bad operand).
// No queueing: start is ignored while busy, including the done cycle.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_serial_addsub_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q, result_q;
    logic           sub_q, carry_q, carry_out_q, neg_q, err_q, busy_q, done_q;
    logic [IW-1:0]  idx;
    logic [IW+1:0]  base;
    logic [3:0]     a_dig, b_dig, r_dig, op_x, op_y, dig_sum;
    logic [4:0]     t, t_adj;
    logic           c_nxt, last, accept, op_bad;

    function automatic logic has_bad(input logic [W-1:0] v);
        has_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
        end
    endfunction

    assign base   = {idx, 2'b00};
    assign last   = (idx == IW'(DIGITS - 1));
    // The done cycle sits in IDLE with busy still high, so busy_q blocks a start there.
    assign accept = (state == IDLE) && !busy_q && bus.start;
    assign op_bad = has_bad(bus.a) | has_bad(bus.b);

    // One decimal digit slice, shared by the add pass and the recomplement pass.
    always_comb begin
        a_dig = a_q[base +: 4];
        b_dig = b_q[base +: 4];
        r_dig = result_q[base +: 4];
        op_x  = a_dig;
        op_y  = sub_q ? (4'd9 - b_dig) : b_dig;
        if (state == FIX) begin
            op_x = 4'd9 - r_dig;
            op_y = 4'd0;
        end
        t     = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, carry_q};
        t_adj = t + 5'd6;
        if (t > 5'd9) begin
            dig_sum = t_adj[3:0];
            c_nxt   = 1'b1;
        end else begin
            dig_sum = t[3:0];
            c_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = op_bad ? DONE : ADD;
            ADD:  if (last)   state_nxt = (sub_q && !c_nxt) ? FIX : DONE;
            FIX:  if (last)   state_nxt = DONE;
            DONE:             state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            idx         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q <= (state != IDLE);
            done_q <= (state == DONE);
            case (state)
                IDLE: if (accept) begin
                    a_q         <= bus.a;
                    b_q         <= bus.b;
                    sub_q       <= bus.sub;
                    result_q    <= '0;
                    carry_q     <= bus.sub;
                    carry_out_q <= 1'b0;
                    neg_q       <= 1'b0;
                    err_q       <= op_bad;
                    idx         <= '0;
                end
                ADD: begin
                    result_q[base +: 4] <= dig_sum;
                    carry_q             <= c_nxt;
                    idx                 <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        if (!sub_q) begin
                            carry_out_q <= c_nxt;
                        end else if (!c_nxt) begin
                            // No end-around carry: difference is negative, recomplement with +1.
                            neg_q   <= 1'b1;
                            carry_q <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    result_q[base +: 4] <= dig_sum;
                    carry_q             <= c_nxt;
                    idx                 <= last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed + random bench for bcd_serial_addsub against an integer-arithmetic reference.
module tb_bcd_serial_addsub;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub_if #(.DIGITS(D)) bus ();

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_bcd(input logic [W-1:0] v);
        valid_bcd = 1'b1;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) valid_bcd = 1'b0;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int n = 0;
        int p = 1;
        for (int i = 0; i < D; i++) begin
            n += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // repulse > 0: pulse start again (other operands) in that cycle of the operation.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int repulse);
        logic [W-1:0] exp_res = '0;
        logic exp_co = 1'b0, exp_neg = 1'b0, exp_err = 1'b0;
        int lat, av, bv, lim, cyc;
        bit pulsed = 1'b0;
        lim = 1;
        for (int i = 0; i < D; i++) lim *= 10;
        if (!valid_bcd(a) || !valid_bcd(b)) begin
            exp_err = 1'b1;
            lat = 1;
        end else begin
            av = bcd2int(a);
            bv = bcd2int(b);
            lat = D + 1;
            if (!sub) begin
                exp_res = int2bcd((av + bv) % lim);
                exp_co  = (av + bv) >= lim;
            end else if (av >= bv) begin
                exp_res = int2bcd(av - bv);
            end else begin
                exp_res = int2bcd(bv - av);
                exp_neg = 1'b1;
                lat = 2 * D + 1;
            end
        end

        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.sub = ~sub;
        check({tag, ".busy0"}, 32'(bus.busy), 32'd0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3 * D + 5) begin
            @(posedge clk);
            #1;
            if (pulsed) bus.start = 1'b0;
            cyc++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) begin
                check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            end
            if (cyc == repulse) begin
                bus.a = rand_bcd();
                bus.b = rand_bcd();
                bus.start = 1'b1;
                pulsed = 1'b1;
            end
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
        check({tag, ".carry"}, 32'(bus.carry_out), 32'(exp_co));
        check({tag, ".neg"}, 32'(bus.neg), 32'(exp_neg));
        check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_drop"}, 32'(bus.busy), 32'd0);
        check({tag, ".hold"}, 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.carry", 32'(bus.carry_out), 32'd0);
        check("rst.neg", 32'(bus.neg), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add0999", 16'h0999, 16'h0001, 1'b0, 0);
        run_op("add9999", 16'h9999, 16'h0001, 1'b0, 0);
        run_op("add0458", 16'h0458, 16'h0367, 1'b0, 0);
        run_op("sub0123", 16'h0123, 16'h0050, 1'b1, 0);
        run_op("sub0050", 16'h0050, 16'h0123, 1'b1, 0);
        run_op("sub0042", 16'h0042, 16'h0042, 1'b1, 0);
        run_op("bad00A1", 16'h00A1, 16'h0005, 1'b0, 0);
        run_op("badb", 16'h1234, 16'hF000, 1'b1, 0);
        run_op("repulse", 16'h1234, 16'h4321, 1'b0, 2);
        run_op("repulse_sub", 16'h0001, 16'h0999, 1'b1, 5);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        bus.a = 16'h9999;
        bus.b = 16'h0001;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.result", 32'(bus.result), 32'd0);
        check("abort.carry", 32'(bus.carry_out), 32'd0);
        check("abort.err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * D + 2; k++) begin
            @(posedge clk);
            #1;
            check("abort.nodone", 32'(bus.done), 32'd0);
        end
        run_op("after_abort", 16'h0458, 16'h0367, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
